lsu_mem_port: RTL and testbench

Load/store sequencer between the core's memory stage and the data port of the unified word memory. Turns one core request (lb/lh/lw/lbu/lhu/sb/sh/sw) into the memory-port cycles it needs. Loads take one registered read plus extraction and sign/zero extension. Stores become read-modify-write sequences: one word, or two words when the access crosses a word boundary. The memory is only ever written with full aligned words.

---
 rtl/lsu_mem_port.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store sequencer between the core memory stage and a word-wide data port.
// Define LSU_MISALIGN_SPLIT_EN to split boundary-crossing stores into two read-modify-writes.
// Without it, misaligned halfword/word accesses are rejected.
module lsu_mem_port #(
  parameter int WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORD_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [WORD_LEN-1:0] mem_d_addr,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_wen,
  output logic [1:0]          mem_wty,
  output logic [WORD_LEN-1:0] mem_wdata,
  output logic [2:0]          dbg_state
);

  // Handshake: a request transfers on a cycle with req_valid && req_ready.
  // resp_valid is a single-cycle pulse with no backpressure.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_RD  = 3'd1,
    ST_RD0 = 3'd2,
    ST_WR0 = 3'd3,
    ST_RD1 = 3'd4,
    ST_WR1 = 3'd5,
    RESP   = 3'd6
  } state_t;

  state_t state, state_next;

  logic [WORD_LEN-1:0] addr_q, wdata_q, word_addr;
  logic [2:0]          funct3_q;
  logic                wen_q, err_q;
  logic                req_illegal, req_misaligned;
  int                  off_i, size_i, end_i;

  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
      3'b100, 3'b101:         req_illegal = req_wen;
      default:                req_illegal = 1'b1;
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    req_misaligned = 1'b0;
`else
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        wen_q    <= req_wen;
        err_q    <= req_illegal || req_misaligned;
      end
    end
  end

  // Byte span of the access relative to the aligned word: [off_i, end_i).
  always_comb begin
    off_i  = {30'd0, addr_q[1:0]};
    size_i = 4;
    case (funct3_q[1:0])
      2'b00:   size_i = 1;
      2'b01:   size_i = 2;
      default: size_i = 4;
    endcase
    end_i     = off_i + size_i;
    word_addr = {addr_q[WORD_LEN-1:2], 2'b00};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal || req_misaligned) state_next = RESP;
          else if (req_wen)                  state_next = ST_RD0;
          else                               state_next = LD_RD;
        end
      end
      LD_RD:  state_next = RESP;
      ST_RD0: state_next = ST_WR0;
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_WR0: state_next = (end_i > 4) ? ST_RD1 : RESP;
`else
      ST_WR0: state_next = RESP;
`endif
      ST_RD1: state_next = ST_WR1;
      ST_WR1: state_next = RESP;
      RESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    mem_wty    = 2'b10;
    mem_wen    = (state == ST_WR0) || (state == ST_WR1);
    dbg_state  = state;
    mem_d_addr = '0;
    case (state)
      LD_RD:          mem_d_addr = addr_q;
      ST_RD0, ST_WR0: mem_d_addr = word_addr;
      ST_RD1, ST_WR1: mem_d_addr = word_addr + WORD_LEN'(4);
      default:        mem_d_addr = '0;
    endcase

    // Merge store bytes into the word read back on the previous cycle.
    mem_wdata = '0;
    if (mem_wen) begin
      mem_wdata = mem_rdata;
      for (int k = 0; k < 4; k++) begin
        if (state == ST_WR0) begin
          if (k >= off_i && k < end_i) mem_wdata[8*k +: 8] = wdata_q[8*(k-off_i) +: 8];
        end else if (k < end_i - 4) begin
          mem_wdata[8*k +: 8] = wdata_q[8*(k+4-off_i) +: 8];
        end
      end
    end

    resp_rdata = '0;
    if (state == RESP && !err_q && !wen_q) begin
      case (funct3_q)
        3'b000:  resp_rdata = {{(WORD_LEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
        3'b001:  resp_rdata = {{(WORD_LEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
        3'b010:  resp_rdata = mem_rdata;
        3'b100:  resp_rdata = {{(WORD_LEN-8){1'b0}}, mem_rdata[7:0]};
        3'b101:  resp_rdata = {{(WORD_LEN-16){1'b0}}, mem_rdata[15:0]};
        default: resp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a byte-addressed registered-read memory model.
module tb_lsu_mem_port;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wen = 1'b0;
  logic [2:0]   req_funct3 = 3'b000;
  logic [W-1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         resp_valid;
  logic [W-1:0] resp_rdata;
  logic         resp_err;
  logic [W-1:0] mem_d_addr;
  logic [W-1:0] mem_rdata = '0;
  logic         mem_wen;
  logic [1:0]   mem_wty;
  logic [W-1:0] mem_wdata;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  lsu_mem_port #(.WORD_LEN(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_d_addr(mem_d_addr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_wty(mem_wty), .mem_wdata(mem_wdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Memory model: 1 KiB, little-endian, one-cycle registered read, full-word writes.
  logic [7:0] mem [0:1023];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[int'((a + 32'(k)) & 32'h3FF)];
    return w;
  endfunction

  task automatic mem_set(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) mem[int'((a + 32'(k)) & 32'h3FF)] = d[8*k +: 8];
  endtask

  always @(posedge clk) begin
    mem_rdata <= rd_word(mem_d_addr);
    if (mem_wen)
      for (int k = 0; k < 4; k++) mem[int'((mem_d_addr + 32'(k)) & 32'h3FF)] = mem_wdata[8*k +: 8];
  end

  // Results of the last run_req, indexed by cycles after the accept edge.
  logic        r_ready;
  int          r_resp_at;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_busy_ready;
  logic        r_traffic;
  logic [31:0] r_cyc1_addr;
  int          wr_cnt;
  logic [31:0] wr_addr [0:3];
  logic [31:0] wr_data [0:3];
  int          wr_cyc  [0:3];

  task automatic run_req(input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    r_ready    = req_ready;
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    r_resp_at = -1; r_rdata = '0; r_err = 1'b0; r_busy_ready = 1'b0;
    r_traffic = 1'b0; r_cyc1_addr = '0; wr_cnt = 0;
    for (int i = 1; i <= 8 && r_resp_at < 0; i++) begin
      @(negedge clk);
      if (i == 1) r_cyc1_addr = mem_d_addr;
      if (mem_d_addr != '0 || mem_wen) r_traffic = 1'b1;
      if (req_ready) r_busy_ready = 1'b1;
      if (mem_wen && wr_cnt < 4) begin
        wr_addr[wr_cnt] = mem_d_addr;
        wr_data[wr_cnt] = mem_wdata;
        wr_cyc[wr_cnt]  = i;
        wr_cnt++;
      end
      if (resp_valid) begin
        r_resp_at = i;
        r_rdata   = resp_rdata;
        r_err     = resp_err;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rst_wen_during: got %b expected 0", mem_wen); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h expected 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b expected 0", resp_err); end
    checks++; if (mem_d_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_d_addr); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rst_mem_wen: got %b expected 0", mem_wen); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (mem_wty !== 2'b10) begin errors++; $display("FAIL rst_mem_wty: got %b expected 10", mem_wty); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_load();
    mem_set(32'h100, 32'hDEADBEEF);
    run_req(1'b0, 3'b010, 32'h100, 32'h0);
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL lw_ready: got %b expected 1", r_ready); end
    checks++; if (r_resp_at !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", r_resp_at); end
    checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", r_rdata); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", r_err); end
    checks++; if (r_busy_ready !== 1'b0) begin errors++; $display("FAIL lw_busy_ready: got %b expected 0", r_busy_ready); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL lw_writes: got %0d expected 0", wr_cnt); end

    mem_set(32'h100, 32'h80FF1234);
    run_req(1'b0, 3'b000, 32'h103, 32'h0);
    checks++; if (r_cyc1_addr !== 32'h103) begin errors++; $display("FAIL lb_addr: got %h expected 103", r_cyc1_addr); end
    checks++; if (r_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", r_rdata); end
    run_req(1'b0, 3'b100, 32'h103, 32'h0);
    checks++; if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h expected 00000080", r_rdata); end
    run_req(1'b0, 3'b001, 32'h102, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_rdata: got %h expected ffff80ff", r_rdata); end
    run_req(1'b0, 3'b101, 32'h102, 32'h0);
    checks++; if (r_rdata !== 32'h000080FF) begin errors++; $display("FAIL lhu_rdata: got %h expected 000080ff", r_rdata); end
    run_req(1'b0, 3'b000, 32'h101, 32'h0);
    checks++; if (r_rdata !== 32'h00000012) begin errors++; $display("FAIL lb_pos_rdata: got %h expected 00000012", r_rdata); end
  endtask

  task automatic test_store();
    mem_set(32'h100, 32'h11223344);
    run_req(1'b1, 3'b000, 32'h101, 32'h000000AB);
    checks++; if (r_cyc1_addr !== 32'h100) begin errors++; $display("FAIL sb_rd_addr: got %h expected 100", r_cyc1_addr); end
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL sb_writes: got %0d expected 1", wr_cnt); end
    checks++; if (wr_addr[0] !== 32'h100 || wr_cyc[0] !== 2) begin errors++; $display("FAIL sb_wr_where: got %h@%0d expected 100@2", wr_addr[0], wr_cyc[0]); end
    checks++; if (wr_data[0] !== 32'h1122AB44) begin errors++; $display("FAIL sb_wdata: got %h expected 1122ab44", wr_data[0]); end
    checks++; if (r_resp_at !== 3) begin errors++; $display("FAIL sb_latency: got %0d expected 3", r_resp_at); end
    checks++; if (r_rdata !== 32'h0 || r_err !== 1'b0) begin errors++; $display("FAIL sb_resp: got %h/%b expected 0/0", r_rdata, r_err); end

    mem_set(32'h100, 32'h11223344);
    run_req(1'b1, 3'b001, 32'h102, 32'h1234BEEF);
    checks++; if (rd_word(32'h100) !== 32'hBEEF3344) begin errors++; $display("FAIL sh_mem: got %h expected beef3344", rd_word(32'h100)); end

    mem_set(32'h108, 32'h55555555);
    run_req(1'b1, 3'b010, 32'h108, 32'h0A0B0C0D);
    checks++; if (rd_word(32'h108) !== 32'h0A0B0C0D) begin errors++; $display("FAIL sw_mem: got %h expected 0a0b0c0d", rd_word(32'h108)); end
    checks++; if (r_resp_at !== 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", r_resp_at); end
  endtask

  task automatic test_crossing();
    mem_set(32'h100, 32'h00000000);
    mem_set(32'h104, 32'h77777777);
    run_req(1'b1, 3'b010, 32'h103, 32'hCAFEBEBE);
`ifdef LSU_MISALIGN_SPLIT_EN
    checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL x_writes: got %0d expected 2", wr_cnt); end
    checks++; if (wr_addr[0] !== 32'h100 || wr_cyc[0] !== 2 || wr_data[0] !== 32'hBE000000) begin
      errors++; $display("FAIL x_word0: got %h@%0d=%h expected 100@2=be000000", wr_addr[0], wr_cyc[0], wr_data[0]); end
    checks++; if (wr_addr[1] !== 32'h104 || wr_cyc[1] !== 4 || wr_data[1] !== 32'h77CAFEBE) begin
      errors++; $display("FAIL x_word1: got %h@%0d=%h expected 104@4=77cafebe", wr_addr[1], wr_cyc[1], wr_data[1]); end
    checks++; if (r_resp_at !== 5 || r_err !== 1'b0) begin errors++; $display("FAIL x_resp: got %0d/%b expected 5/0", r_resp_at, r_err); end
`else
    checks++; if (r_resp_at !== 1 || r_err !== 1'b1) begin errors++; $display("FAIL x_resp: got %0d/%b expected 1/1", r_resp_at, r_err); end
    checks++; if (wr_cnt !== 0 || r_traffic !== 1'b0) begin errors++; $display("FAIL x_traffic: got %0d/%b expected 0/0", wr_cnt, r_traffic); end
    run_req(1'b0, 3'b001, 32'h101, 32'h0);
    checks++; if (r_resp_at !== 1 || r_err !== 1'b1 || r_traffic !== 1'b0) begin
      errors++; $display("FAIL lh_misalign: got %0d/%b/%b expected 1/1/0", r_resp_at, r_err, r_traffic); end
`endif
  endtask

  task automatic test_errors();
    mem_set(32'h100, 32'h12345678);
    run_req(1'b0, 3'b011, 32'h100, 32'h0);
    checks++; if (r_resp_at !== 1 || r_err !== 1'b1) begin errors++; $display("FAIL ld011_resp: got %0d/%b expected 1/1", r_resp_at, r_err); end
    checks++; if (r_rdata !== 32'h0 || r_traffic !== 1'b0) begin errors++; $display("FAIL ld011_quiet: got %h/%b expected 0/0", r_rdata, r_traffic); end
    run_req(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF);
    checks++; if (r_resp_at !== 1 || r_err !== 1'b1) begin errors++; $display("FAIL st100_resp: got %0d/%b expected 1/1", r_resp_at, r_err); end
    checks++; if (wr_cnt !== 0 || r_traffic !== 1'b0) begin errors++; $display("FAIL st100_quiet: got %0d/%b expected 0/0", wr_cnt, r_traffic); end
    checks++; if (rd_word(32'h100) !== 32'h12345678) begin errors++; $display("FAIL st100_mem: got %h expected 12345678", rd_word(32'h100)); end
  endtask

  task automatic test_back_to_back();
    mem_set(32'h200, 32'hA1B2C3D4);
    run_req(1'b1, 3'b000, 32'h200, 32'h00000099);
    run_req(1'b0, 3'b010, 32'h200, 32'h0);
    checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", r_ready); end
    checks++; if (r_resp_at !== 2 || r_rdata !== 32'hA1B2C399) begin errors++; $display("FAIL b2b_load: got %0d/%h expected 2/a1b2c399", r_resp_at, r_rdata); end
  endtask

  task automatic test_reset_mid();
    logic saw_resp;
    logic saw_not_ready;
`ifdef LSU_MISALIGN_SPLIT_EN
    mem_set(32'h100, 32'h00000000);
    mem_set(32'h104, 32'h55555555);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010; req_addr = 32'h102; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dbg_state !== 3'd4) begin errors++; $display("FAIL rm_state: got %0d expected 4", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_wen !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL rm_async: got %b/%0d expected 0/0", mem_wen, dbg_state); end
`else
    mem_set(32'h100, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b000; req_addr = 32'h101; req_wdata = 32'h000000AB;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wen = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL rm_wen_before: got %b expected 1", mem_wen); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_wen !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL rm_async: got %b/%0d expected 0/0", mem_wen, dbg_state); end
`endif
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    saw_not_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
      if (!req_ready) saw_not_ready = 1'b1;
    end
    checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL rm_no_resp: got %b expected 0", saw_resp); end
    checks++; if (saw_not_ready !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b expected 0", saw_not_ready); end
`ifdef LSU_MISALIGN_SPLIT_EN
    checks++; if (rd_word(32'h100) !== 32'h33440000) begin errors++; $display("FAIL rm_word0: got %h expected 33440000", rd_word(32'h100)); end
    checks++; if (rd_word(32'h104) !== 32'h55555555) begin errors++; $display("FAIL rm_word1: got %h expected 55555555", rd_word(32'h104)); end
`else
    checks++; if (rd_word(32'h100) !== 32'h11223344) begin errors++; $display("FAIL rm_word0: got %h expected 11223344", rd_word(32'h100)); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_load();
    test_store();
    test_crossing();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
